// File: rtl/cnt4_seq_pkg.sv
// Shared types and defaults for the 4-bit sequencing counter.
package cnt4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam int CNT_WIDTH   = 4;
  localparam int CNT_MAX_VAL = 15;

endpackage

// File: rtl/cnt4_seq_if.sv
// Control/status bundle between the counter and its controller.
interface cnt4_seq_if import cnt4_pkg::*; #(
  parameter int WIDTH = CNT_WIDTH
);
  logic             start;
  logic             stop;
  logic             en;
  logic             up;
  logic             one_shot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_p;

  modport master (
    output start, stop, en, up, one_shot, load, load_val,
    input  count, busy, done, tc_p
  );

  modport slave (
    input  start, stop, en, up, one_shot, load, load_val,
    output count, busy, done, tc_p
  );
endinterface

// File: rtl/cnt4_seq.sv
// Up/down modulo-(MAX_VAL+1) counter with IDLE/RUN/DONE sequencing and a
// registered terminal pulse. count feeds the downstream capture register.
module cnt4_seq import cnt4_pkg::*; #(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MAX_VAL = CNT_MAX_VAL
) (
  input  logic        clk,
  input  logic        reset,
  cnt4_seq_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, term, step;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;

  // Terminal value tracks the live direction so a mid-run flip retargets it.
  always_comb begin
    term = bus.up ? MAXV : '0;
    if (bus.up) step = (cnt_q == MAXV) ? '0   : cnt_q + WIDTH'(1);
    else        step = (cnt_q == '0)   ? MAXV : cnt_q - WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.load_val > MAXV) ? MAXV : bus.load_val;
    end else if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start && state_q != RUN) begin
      state_d = RUN;
      mode_d  = bus.one_shot;
    end else if (state_q == RUN && bus.en) begin
      if (cnt_q == term) begin
        // Terminal edge: one-shot parks in DONE, continuous mode wraps.
        tc_d = 1'b1;
        if (mode_q) state_d = DONE;
        else        cnt_d   = step;
      end else begin
        cnt_d = step;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.count = cnt_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.tc_p  = tc_q;

endmodule

// File: doc/cnt4_seq.md
# cnt4_seq

- Programmable 4-bit up/down sequencing counter with a run/stop/done state machine.
- Sits directly upstream of the 4-bit capture register: `count` drives that register's data input every cycle.
- Supports continuous (wrapping) and one-shot modes, synchronous parallel load, and a count-enable.
- Emits status flags and a single-cycle terminal pulse for downstream control.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits.
- `MAX_VAL`, 15: wrap limit; must satisfy `MAX_VAL` ≤ 2^`WIDTH`−1. Count range is 0..`MAX_VAL`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `start`  in  1  level sampled per cycle; IDLE or DONE → RUN.
- `stop`  in  1  RUN or DONE → IDLE; count held.
- `en`  in  1  count enable; counting occurs only in RUN with `en`=1.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled every counting cycle.
- `one_shot`  in  1  mode, latched when RUN is entered: 1 = stop at terminal, 0 = wrap.
- `load`  in  1  synchronous parallel load of `load_val`.
- `load_val`  in  `WIDTH`  load value; values > `MAX_VAL` load as `MAX_VAL`.
- `count`  out  `WIDTH`  registered count value.
- `busy`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `tc_p`  out  1  registered one-cycle terminal pulse.

## Operation
- States:
  - IDLE (reset state): count held.
  - RUN: count steps when `en`=1.
  - DONE: reached only in one-shot mode; count held.
- Terminal value: `MAX_VAL` when `up`=1, 0 when `up`=0.
- Per-edge priority, highest first: reset > `load` > `stop` > `start` > count step.
- `load`:
  - Overrides count in any state; state unchanged.
  - No step occurs that cycle.
  - `tc_p`=0 that cycle.
- `stop`: forces IDLE from any state; wins over a simultaneous `start`.
- `start` in RUN: no effect, and `one_shot` is not re-latched.
- Continuous step (RUN, `en`=1, latched `one_shot`=0):
  - Up: `MAX_VAL` → 0.
  - Down: 0 → `MAX_VAL`.
  - The wrap edge sets `tc_p` for one cycle.
- One-shot step (RUN, `en`=1, latched `one_shot`=1):
  - If count already equals the terminal value, count holds, state → DONE, and `tc_p` is set for one cycle.
  - Otherwise the count steps normally.
- DONE: count held until `start` (re-enter RUN, count from current value) or `stop`.
- Direction change mid-run takes effect on the next counting edge; terminal value follows the current `up`.
- All arithmetic is modulo (`MAX_VAL`+1); no intermediate value outside 0..`MAX_VAL` ever appears on `count`.

## Timing
- Reset values: `count`=0, `busy`=0, `done`=0, `tc_p`=0, state=IDLE, latched mode=0.
- Reset assertion clears outputs asynchronously; deassertion takes effect at the next rising edge.
- `start` sampled high at edge k → `busy`=1 after edge k; first step at edge k+1 (if `en`=1).
- Step latency: `count` changes one edge after `en`=1 is sampled in RUN.
- `load` at edge k → `count`=`load_val` after edge k.
- `tc_p`:
  - High for exactly the cycle following the wrap or DONE-entry edge.
  - Never high two consecutive cycles unless `MAX_VAL`=0.
- Reset mid-run: immediate return to IDLE with count 0; a pending `tc_p` is dropped.

## Structure
- Shared package `cnt4_pkg`:
  - State enum `cnt_state_t` (IDLE, RUN, DONE).
  - Default `WIDTH`/`MAX_VAL` constants.
- Single module; no sub-module needed.
- Next-count logic is combinational, feeding a single registered process.
- Top-level test wiring instantiates `cnt4_seq` feeding the existing 4-bit register to check the end-to-end pipeline (register output lags `count` by one cycle).

## Test plan
- Reset/idle: hold `reset`=0 for 2 cycles, release → `count`=0, `busy`=0, `done`=0, `tc_p`=0; `start`=0 for 5 cycles → `count` stays 0.
- Continuous up wrap: `MAX_VAL`=15, `start` pulse, `en`=1, `up`=1 → `count` 0,1,…,15,0; `tc_p`=1 only in the cycle after 15→0.
- Down, one-shot: `load_val`=3 with `load`, then `start` with `one_shot`=1, `up`=0 → `count` 3,2,1,0,0; `done`=1 and `busy`=0 after the hold edge; `tc_p` one pulse.
- Priority: in RUN at `count`=5, assert `load`=1 (`load_val`=9), `stop`=1 and `start`=1 together → `count`=9, state stays RUN. Next cycle `stop`=1 and `start`=1 → IDLE, `count`=9.
- Load saturation and modulus: `MAX_VAL`=9, `load_val`=12 → `count`=9; then up step → 0 with `tc_p`.
- Async reset mid-run: `count`=7, `busy`=1; drop `reset` between edges → outputs 0 immediately, before the next edge; release → IDLE.
